// File: rtl/spi_rdid_responder.sv
// ---------------------------------------------------------------------------
// spi_rdid_responder
//
// SPI mode-0 target that answers the Read Identification command (0x9F by
// default) with a 24-bit JEDEC ID {MAN_ID, MEM_TYPE, MEM_CAP}, MSB first.
// Any other command byte is captured and reported, and the rest of the frame
// is ignored. While chip select stays low, the ID repeats.
//
// All SPI inputs are oversampled in the clk domain, so clk must run at least
// 8x the SCK frequency. No logic is clocked by spisck.
//
// Ports
//   clk          system clock
//   rst_n        synchronous active-low reset
//   spisck       SPI clock from the master (idles low)
//   spimosi      master-out serial data, MSB first
//   chip_select  active-low select from the master
//   spimiso      serial ID data, MSB first; 0 when not sending
//   spimiso_oe   high while the ID is being driven
//   cmd_byte     last complete command byte; held until the next one
//   cmd_strobe   one-clk pulse when cmd_byte updates
//   rdid_done    one-clk pulse after the 24th ID bit has been shifted out
//   busy         high whenever the FSM is not idle
// ---------------------------------------------------------------------------
module spi_rdid_responder #(
  parameter logic [7:0] RDID_CODE = 8'h9F,
  parameter logic [7:0] MAN_ID    = 8'h20,
  parameter logic [7:0] MEM_TYPE  = 8'h20,
  parameter logic [7:0] MEM_CAP   = 8'h15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       spisck,
  input  logic       spimosi,
  input  logic       chip_select,
  output logic       spimiso,
  output logic       spimiso_oe,
  output logic [7:0] cmd_byte,
  output logic       cmd_strobe,
  output logic       rdid_done,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE,
    RECV_CMD,
    SEND_ID,
    IGNORE
  } state_t;

  localparam logic [4:0] ID_TOP = 5'd23;

  // -------------------------------------------------------------------------
  // Input synchronizers and edge detection.
  // Index 1 is the synchronized value, index 2 its previous-cycle copy.
  // -------------------------------------------------------------------------
  logic [2:0] sck_sync;
  logic [1:0] mosi_sync;
  logic [2:0] cs_sync;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sck_sync  <= '0;
      mosi_sync <= '0;
      cs_sync   <= '1;
    end else begin
      sck_sync  <= {sck_sync[1:0], spisck};
      mosi_sync <= {mosi_sync[0], spimosi};
      cs_sync   <= {cs_sync[1:0], chip_select};
    end
  end

  logic sck_rise;
  logic sck_fall;
  logic mosi_s;
  logic cs_active;
  logic cs_release;

  assign sck_rise   =  sck_sync[1] & ~sck_sync[2];
  assign sck_fall   = ~sck_sync[1] &  sck_sync[2];
  assign mosi_s     =  mosi_sync[1];
  assign cs_active  = ~cs_sync[1];
  // Every non-idle state is entered with cs_active high, so the deassertion
  // edge is the only way it can ever drop while busy.
  assign cs_release =  cs_sync[1] & ~cs_sync[2];

  // -------------------------------------------------------------------------
  // State and datapath registers
  // -------------------------------------------------------------------------
  state_t      state;
  state_t      state_next;

  logic [2:0]  bit_cnt;
  // Only seven bits are kept: the eighth arrives on mosi_s in the same cycle
  // the full byte is assembled into cmd_byte.
  logic [6:0]  cmd_shift;
  logic [23:0] id_reg;
  logic [4:0]  id_cnt;
  // The first SCK fall after entering SEND_ID ends command bit 0; bit 23 is
  // already on MISO, so that fall must not advance the counter.
  logic        first_fall;

  logic [7:0]  rx_byte;
  logic        shift_en;
  logic        cmd_done;
  logic        cmd_is_rdid;
  logic        id_step;
  logic        id_wrap;

  assign rx_byte     = {cmd_shift, mosi_s};
  assign cmd_is_rdid = (rx_byte == RDID_CODE);

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next state and datapath controls.
  // CS deassertion is checked first so it wins over a coincident SCK edge.
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    shift_en   = 1'b0;
    cmd_done   = 1'b0;
    id_step    = 1'b0;
    id_wrap    = 1'b0;

    unique case (state)
      IDLE: begin
        if (cs_active) begin
          state_next = RECV_CMD;
        end
      end

      RECV_CMD: begin
        if (cs_release) begin
          state_next = IDLE;
        end else if (sck_rise) begin
          shift_en = 1'b1;
          if (bit_cnt == 3'd7) begin
            cmd_done   = 1'b1;
            state_next = cmd_is_rdid ? SEND_ID : IGNORE;
          end
        end
      end

      SEND_ID: begin
        if (cs_release) begin
          state_next = IDLE;
        end else if (sck_fall && !first_fall) begin
          id_step = 1'b1;
          id_wrap = (id_cnt == 5'd0);
        end
      end

      IGNORE: begin
        if (cs_release) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bit_cnt    <= '0;
      cmd_shift  <= '0;
      cmd_byte   <= '0;
      cmd_strobe <= 1'b0;
      id_reg     <= '0;
      id_cnt     <= '0;
      first_fall <= 1'b1;
      rdid_done  <= 1'b0;
    end else begin
      cmd_strobe <= 1'b0;
      rdid_done  <= 1'b0;

      if (state == IDLE) begin
        bit_cnt    <= '0;
        cmd_shift  <= '0;
        id_cnt     <= '0;
        first_fall <= 1'b1;
      end

      if (shift_en) begin
        cmd_shift <= rx_byte[6:0];
        bit_cnt   <= bit_cnt + 3'd1;
      end

      if (cmd_done) begin
        cmd_byte   <= rx_byte;
        cmd_strobe <= 1'b1;
        id_reg     <= {MAN_ID, MEM_TYPE, MEM_CAP};
        id_cnt     <= ID_TOP;
        first_fall <= 1'b1;
      end

      if (state == SEND_ID && !cs_release && sck_fall && first_fall) begin
        first_fall <= 1'b0;
      end

      if (id_step) begin
        if (id_wrap) begin
          id_cnt    <= ID_TOP;
          rdid_done <= 1'b1;
        end else begin
          id_cnt    <= id_cnt - 5'd1;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  always_comb begin
    spimiso    = 1'b0;
    spimiso_oe = 1'b0;
    if (state == SEND_ID) begin
      spimiso    = id_reg[id_cnt];
      spimiso_oe = 1'b1;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_spi_rdid_responder.sv
// ---------------------------------------------------------------------------
// tb_spi_rdid_responder
//
// Bench for spi_rdid_responder. A bus-functional SPI master (SCK = clk/8)
// drives frames; expected command bytes and ID bytes are queued as the
// stimulus is driven and compared as the DUT produces them.
// ---------------------------------------------------------------------------
module tb_spi_rdid_responder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       spisck = 1'b0;
  logic       spimosi = 1'b0;
  logic       chip_select = 1'b1;
  logic       spimiso;
  logic       spimiso_oe;
  logic [7:0] cmd_byte;
  logic       cmd_strobe;
  logic       rdid_done;
  logic       busy;

  spi_rdid_responder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .spisck      (spisck),
    .spimosi     (spimosi),
    .chip_select (chip_select),
    .spimiso     (spimiso),
    .spimiso_oe  (spimiso_oe),
    .cmd_byte    (cmd_byte),
    .cmd_strobe  (cmd_strobe),
    .rdid_done   (rdid_done),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  logic [7:0] exp_cmd_q[$];
  logic [7:0] exp_id_q[$];
  logic [7:0] id_bytes [3] = '{8'h20, 8'h20, 8'h15};

  int unsigned strobe_cnt = 0;
  int unsigned done_cnt   = 0;
  logic        oe_seen    = 1'b0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Output monitor, sampled on the inactive clock edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (cmd_strobe) begin
        strobe_cnt++;
        if (exp_cmd_q.size() == 0) begin
          check("unexp_strobe", {31'b0, cmd_strobe}, 32'd0);
        end else begin
          check("cmd_byte", {24'b0, cmd_byte}, {24'b0, exp_cmd_q.pop_front()});
        end
      end
      if (rdid_done) done_cnt++;
      if (spimiso_oe) oe_seen = 1'b1;
    end
  end

  task automatic check_reset_outputs(input string where);
    check({where, "_miso"},   {31'b0, spimiso},    32'd0);
    check({where, "_oe"},     {31'b0, spimiso_oe}, 32'd0);
    check({where, "_cmd"},    {24'b0, cmd_byte},   32'd0);
    check({where, "_strobe"}, {31'b0, cmd_strobe}, 32'd0);
    check({where, "_done"},   {31'b0, rdid_done},  32'd0);
    check({where, "_busy"},   {31'b0, busy},       32'd0);
  endtask

  task automatic clear_counts();
    strobe_cnt = 0;
    done_cnt   = 0;
    oe_seen    = 1'b0;
  endtask

  task automatic send_cmd_bits(input logic [7:0] cmd, input int nbits);
    for (int i = 7; i > 7 - nbits; i--) begin
      spisck  = 1'b0;
      spimosi = cmd[i];
      repeat (4) @(negedge clk);
      spisck = 1'b1;
      repeat (4) @(negedge clk);
    end
    spisck = 1'b0;
  endtask

  // Full frame: command byte, then id_bits master clocks reading MISO.
  // rst_at >= 0 asserts reset just before ID bit rst_at is sampled.
  task automatic xfer(input logic [7:0] cmd, input int id_bits, input int rst_at);
    logic [7:0] cap;
    logic       is_rdid;
    cap     = '0;
    is_rdid = (cmd == 8'h9F);
    clear_counts();
    @(negedge clk);
    chip_select = 1'b0;
    repeat (4) @(negedge clk);
    exp_cmd_q.push_back(cmd);
    send_cmd_bits(cmd, 8);
    for (int b = 0; b < id_bits; b++) begin
      if (b % 8 == 0) exp_id_q.push_back(is_rdid ? id_bytes[(b / 8) % 3] : 8'h00);
      repeat (4) @(negedge clk);
      if (b == rst_at) begin
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("midrst");
        rst_n       = 1'b1;
        chip_select = 1'b1;
        exp_id_q.delete();
        repeat (8) @(negedge clk);
        return;
      end
      cap    = {cap[6:0], spimiso};
      spisck = 1'b1;
      repeat (4) @(negedge clk);
      spisck = 1'b0;
      if (b % 8 == 7) begin
        check(is_rdid ? "id_byte" : "miso_idle", {24'b0, cap},
              {24'b0, exp_id_q.pop_front()});
      end
    end
    repeat (4) @(negedge clk);
    chip_select = 1'b1;
    repeat (8) @(negedge clk);
    check("busy_after_cs", {31'b0, busy}, 32'd0);
  endtask

  initial begin
    // Reset with random SPI activity.
    rst_n = 1'b0;
    repeat (4) begin
      @(negedge clk);
      spisck      = 1'($urandom_range(0, 1));
      spimosi     = 1'($urandom_range(0, 1));
      chip_select = 1'($urandom_range(0, 1));
    end
    check_reset_outputs("reset");
    spisck      = 1'b0;
    chip_select = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Plain RDID read.
    xfer(8'h9F, 24, -1);
    check("rdid_strobes", strobe_cnt, 32'd1);
    check("rdid_done", done_cnt, 32'd1);
    check("rdid_oe", {31'b0, oe_seen}, 32'd1);

    // Wrong command.
    xfer(8'h05, 24, -1);
    check("wrong_strobes", strobe_cnt, 32'd1);
    check("wrong_done", done_cnt, 32'd0);
    check("wrong_oe", {31'b0, oe_seen}, 32'd0);

    // Abort after 5 command bits, then a full read.
    clear_counts();
    @(negedge clk);
    chip_select = 1'b0;
    repeat (4) @(negedge clk);
    send_cmd_bits(8'h9F, 5);
    repeat (4) @(negedge clk);
    chip_select = 1'b1;
    repeat (8) @(negedge clk);
    check("abort_strobes", strobe_cnt, 32'd0);
    check("abort_cmd_hold", {24'b0, cmd_byte}, 32'h05);
    check("abort_busy", {31'b0, busy}, 32'd0);
    xfer(8'h9F, 24, -1);
    check("post_abort_done", done_cnt, 32'd1);

    // ID wrap: 48 bits.
    xfer(8'h9F, 48, -1);
    check("wrap_done", done_cnt, 32'd2);
    check("wrap_strobes", strobe_cnt, 32'd1);

    // Reset during the ID phase, then a clean read.
    xfer(8'h9F, 24, 10);
    check("midrst_done", done_cnt, 32'd0);
    xfer(8'h9F, 24, -1);
    check("after_rst_done", done_cnt, 32'd1);
    check("after_rst_cmd", {24'b0, cmd_byte}, 32'h9F);
    check("cmd_q_drained", exp_cmd_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
